ram_port_arbiter: RTL and testbench

- Shares the single-port data/instruction RAM between two requesters: the CPU datapath (fetch, load, store) and a host/loader port used for program download and debug readback.
- Sits between the datapath address/data muxes, the host interface and the RAM macro.
- Grants one access per cycle. Uses round-robin priority with a bounded host lock for bursts. Returns synchronous-read data to the requester that issued the read.

---
 rtl/ram_port_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_ram_port_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_port_arbiter.sv
// Arbitrates the shared single-port RAM between the CPU datapath and the host/loader port.
// Optional grant/stall performance counters are built when ARB_PERF_COUNT_EN is defined.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// IDLE        | no lock; halt gives host priority, else round-robin on ties
// HOST_LOCKED | host owns the RAM for a burst; CPU is never granted
// CPU_SLOT    | one guaranteed CPU opportunity after a full host burst
module ram_port_arbiter #(
  parameter int unsigned ADDR_W    = 5,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned MAX_BURST = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  input  logic              host_lock,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  input  logic              cpu_halted,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
`ifdef ARB_PERF_COUNT_EN
  ,
  output logic [15:0]       cpu_grant_cnt,
  output logic [15:0]       host_grant_cnt,
  output logic [15:0]       cpu_stall_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    HOST_LOCKED = 2'd1,
    CPU_SLOT    = 2'd2
  } state_t;

  localparam logic       WIN_CPU     = 1'b0;
  localparam logic       WIN_HOST    = 1'b1;
  localparam logic [7:0] MAX_BURST_C = 8'(MAX_BURST);

  state_t              state, state_nxt;
  logic [7:0]          burst_cnt, burst_cnt_nxt;
  logic                last_winner;
  logic                cpu_win, host_win;
  logic                rd_pend, rd_host;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   cpu_rdata_q, host_rdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      burst_cnt <= 8'd0;
    end else begin
      state     <= state_nxt;
      burst_cnt <= burst_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    burst_cnt_nxt = burst_cnt;
    cpu_win       = 1'b0;
    host_win      = 1'b0;
    case (state)
      IDLE: begin
        if (host_req && (cpu_halted || !cpu_req || last_winner == WIN_CPU))
          host_win = 1'b1;
        else if (cpu_req)
          cpu_win = 1'b1;
        burst_cnt_nxt = 8'd0;
        if (host_win && host_lock) begin
          // the granting cycle already counts toward the burst
          burst_cnt_nxt = 8'd1;
          if (MAX_BURST_C <= 8'd1 && cpu_req && !cpu_halted)
            state_nxt = CPU_SLOT;
          else
            state_nxt = HOST_LOCKED;
        end
      end
      HOST_LOCKED: begin
        host_win = host_req;
        if (host_win && burst_cnt != 8'hFF)
          burst_cnt_nxt = burst_cnt + 8'd1;
        if (!host_lock) begin
          state_nxt     = IDLE;
          burst_cnt_nxt = 8'd0;
        end else if (burst_cnt_nxt >= MAX_BURST_C && cpu_req && !cpu_halted) begin
          state_nxt = CPU_SLOT;
        end
      end
      CPU_SLOT: begin
        cpu_win       = cpu_req;
        state_nxt     = IDLE;
        burst_cnt_nxt = 8'd0;
      end
      default: begin
        state_nxt     = IDLE;
        burst_cnt_nxt = 8'd0;
      end
    endcase
  end

  // grants are forced low while reset is asserted, even with requests pending
  assign cpu_gnt  = cpu_win & rst_n;
  assign host_gnt = host_win & rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      last_winner <= WIN_HOST;
    else if (cpu_gnt)
      last_winner <= WIN_CPU;
    else if (host_gnt)
      last_winner <= WIN_HOST;
  end

  always_comb begin
    ram_addr  = addr_q;
    ram_wdata = wdata_q;
    ram_we    = 1'b0;
    if (cpu_gnt) begin
      ram_addr  = cpu_addr;
      ram_wdata = cpu_wdata;
      ram_we    = cpu_we;
    end else if (host_gnt) begin
      ram_addr  = host_addr;
      ram_wdata = host_wdata;
      ram_we    = host_we;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      addr_q  <= ram_addr;
      wdata_q <= ram_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pend <= 1'b0;
      rd_host <= 1'b0;
    end else begin
      rd_pend <= (cpu_gnt & ~cpu_we) | (host_gnt & ~host_we);
      rd_host <= host_gnt;
    end
  end

  assign cpu_rvalid  = rd_pend & ~rd_host;
  assign host_rvalid = rd_pend & rd_host;
  assign cpu_rdata   = cpu_rvalid  ? ram_rdata : cpu_rdata_q;
  assign host_rdata  = host_rvalid ? ram_rdata : host_rdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_rdata_q  <= '0;
      host_rdata_q <= '0;
    end else begin
      cpu_rdata_q  <= cpu_rdata;
      host_rdata_q <= host_rdata;
    end
  end

`ifdef ARB_PERF_COUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_grant_cnt  <= 16'd0;
      host_grant_cnt <= 16'd0;
      cpu_stall_cnt  <= 16'd0;
    end else begin
      if (cpu_gnt && cpu_grant_cnt != 16'hFFFF)
        cpu_grant_cnt <= cpu_grant_cnt + 16'd1;
      if (host_gnt && host_grant_cnt != 16'hFFFF)
        host_grant_cnt <= host_grant_cnt + 16'd1;
      if (cpu_req && !cpu_gnt && cpu_stall_cnt != 16'hFFFF)
        cpu_stall_cnt <= cpu_stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: behavioural RAM macro, read-return scoreboard and per-scenario tasks.
module tb_ram_port_arbiter;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 16;
  localparam int MAX_BURST = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata, cpu_rdata;
  logic host_req, host_we, host_lock, host_gnt, host_rvalid;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata, host_rdata;
  logic cpu_halted;
  logic [ADDR_W-1:0] ram_addr;
  logic ram_we;
  logic [DATA_W-1:0] ram_wdata, ram_rdata;
`ifdef ARB_PERF_COUNT_EN
  logic [15:0] cpu_grant_cnt, host_grant_cnt, cpu_stall_cnt;
`endif

  ram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_lock(host_lock), .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .cpu_halted(cpu_halted),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
`ifdef ARB_PERF_COUNT_EN
    , .cpu_grant_cnt(cpu_grant_cnt), .host_grant_cnt(host_grant_cnt), .cpu_stall_cnt(cpu_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic              host;
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] addr;
  } exp_t;

  exp_t exp_q[$];
  int tests_run = 0;
  int tests_failed = 0;
  logic [DATA_W-1:0] exp_mem [32];

  function automatic logic [DATA_W-1:0] init_val(input logic [ADDR_W-1:0] a);
    return (a == 5'd5) ? 16'h1234 : (16'hA500 ^ {11'd0, a});
  endfunction

  // RAM macro: synchronous read, one-cycle latency, unwritten words return init_val
  logic [DATA_W-1:0] mem [32];
  bit                wr  [32];
  always @(posedge clk) begin
    if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
      wr[ram_addr]  <= 1'b1;
    end
    ram_rdata <= wr[ram_addr] ? mem[ram_addr] : init_val(ram_addr);
  end

  // scoreboard: every read return is matched against the oldest expected read
  always @(negedge clk) begin
    exp_t e;
    if (cpu_rvalid || host_rvalid) begin
      tests_run++;
      if (cpu_rvalid && host_rvalid) begin
        tests_failed++;
        $display("FAIL rvalid_exclusive: cpu_rvalid=%0b host_rvalid=%0b, required at most one", cpu_rvalid, host_rvalid);
      end else if (exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL unexpected_rvalid: cpu_rvalid=%0b host_rvalid=%0b, required no return", cpu_rvalid, host_rvalid);
      end else begin
        e = exp_q.pop_front();
        if (host_rvalid !== e.host || (e.host ? host_rdata : cpu_rdata) !== e.data) begin
          tests_failed++;
          $display("FAIL read_return: addr=%0d got host_rvalid=%0b cpu_rdata=%h host_rdata=%h, required host=%0b data=%h",
                   e.addr, host_rvalid, cpu_rdata, host_rdata, e.host, e.data);
        end
      end
    end
  end

  task automatic cycle(input logic c_req, c_we, input logic [ADDR_W-1:0] c_a, input logic [DATA_W-1:0] c_d,
                       input logic h_req, h_we, input logic [ADDR_W-1:0] h_a, input logic [DATA_W-1:0] h_d,
                       input logic h_lock, halt,
                       output logic cg, hg, we_s, output logic [ADDR_W-1:0] a_s, output logic [DATA_W-1:0] d_s);
    cpu_req = c_req; cpu_we = c_we; cpu_addr = c_a; cpu_wdata = c_d;
    host_req = h_req; host_we = h_we; host_addr = h_a; host_wdata = h_d;
    host_lock = h_lock; cpu_halted = halt;
    @(negedge clk);
    cg = cpu_gnt; hg = host_gnt; we_s = ram_we; a_s = ram_addr; d_s = ram_wdata;
    if (cg) begin
      if (c_we) exp_mem[c_a] = c_d;
      else exp_q.push_back('{host: 1'b0, data: exp_mem[c_a], addr: c_a});
    end
    if (hg) begin
      if (h_we) exp_mem[h_a] = h_d;
      else exp_q.push_back('{host: 1'b1, data: exp_mem[h_a], addr: h_a});
    end
    @(posedge clk); #1;
  endtask

  task automatic idle();
    logic cg, hg, we_s;
    logic [ADDR_W-1:0] a_s;
    logic [DATA_W-1:0] d_s;
    cycle(0, 0, '0, '0, 0, 0, '0, '0, 0, 0, cg, hg, we_s, a_s, d_s);
  endtask

  task automatic do_reset();
    cpu_req = 0; cpu_we = 0; host_req = 0; host_we = 0; host_lock = 0; cpu_halted = 0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    cpu_req = 1; cpu_we = 0; cpu_addr = 5'd3; cpu_wdata = 16'h0;
    host_req = 1; host_we = 1; host_addr = 5'd4; host_wdata = 16'hFFFF;
    host_lock = 0; cpu_halted = 0;
    #1 rst_n = 1'b0;
    #2;
    tests_run++;
    if ({cpu_gnt, host_gnt} !== 2'b00) begin
      tests_failed++; $display("FAIL reset_gnt: got %b, required 00", {cpu_gnt, host_gnt});
    end
    tests_run++;
    if ({cpu_rvalid, host_rvalid, ram_we} !== 3'b000) begin
      tests_failed++; $display("FAIL reset_valid_we: got %b, required 000", {cpu_rvalid, host_rvalid, ram_we});
    end
    tests_run++;
    if ({ram_addr, ram_wdata} !== '0) begin
      tests_failed++; $display("FAIL reset_ram_bus: got addr=%h wdata=%h, required 0", ram_addr, ram_wdata);
    end
    tests_run++;
    if ({cpu_rdata, host_rdata} !== '0) begin
      tests_failed++; $display("FAIL reset_rdata: got cpu=%h host=%h, required 0", cpu_rdata, host_rdata);
    end
    cpu_req = 0; host_req = 0; host_we = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_cpu_read();
    logic cg, hg, we_s;
    logic [ADDR_W-1:0] a_s;
    logic [DATA_W-1:0] d_s;
    cycle(1, 0, 5'd5, '0, 0, 0, '0, '0, 0, 0, cg, hg, we_s, a_s, d_s);
    tests_run++;
    if ({cg, hg} !== 2'b10) begin
      tests_failed++; $display("FAIL cpu_read_gnt: got cpu=%0b host=%0b, required cpu=1 host=0", cg, hg);
    end
    tests_run++;
    if (cpu_rvalid !== 1'b1 || cpu_rdata !== 16'h1234 || host_rvalid !== 1'b0) begin
      tests_failed++;
      $display("FAIL cpu_read_data: got rvalid=%0b rdata=%h host_rvalid=%0b, required 1 1234 0", cpu_rvalid, cpu_rdata, host_rvalid);
    end
    idle();
    tests_run++;
    if (cpu_rvalid !== 1'b0 || cpu_rdata !== 16'h1234) begin
      tests_failed++; $display("FAIL cpu_rdata_hold: got rvalid=%0b rdata=%h, required 0 1234", cpu_rvalid, cpu_rdata);
    end
  endtask

  task automatic test_round_robin();
    logic cg, hg, we_s;
    logic [ADDR_W-1:0] a_s, ca, ha;
    logic [DATA_W-1:0] d_s;
    logic exp_c;
    do_reset();
    ca = 5'd0; ha = 5'd8;
    for (int i = 0; i < 8; i++) begin
      cycle(1, 0, ca, '0, 1, 0, ha, '0, 0, 0, cg, hg, we_s, a_s, d_s);
      exp_c = (i % 2 == 0);
      tests_run++;
      if (cg !== exp_c || hg !== !exp_c) begin
        tests_failed++; $display("FAIL round_robin[%0d]: got cpu=%0b host=%0b, required cpu=%0b host=%0b", i, cg, hg, exp_c, !exp_c);
      end
      if (cg) ca++;
      if (hg) ha++;
    end
    idle();
  endtask

  task automatic test_host_burst();
    logic cg, hg, we_s;
    logic [ADDR_W-1:0] a_s, ca;
    logic [DATA_W-1:0] d_s;
    int hn;
    logic exp_c;
    do_reset();
    ca = 5'd0; hn = 0;
    for (int i = 0; i < 19; i++) begin
      cycle(1, 0, ca, '0, 1, 1, 5'(16 + hn), 16'(16'hC000 + hn), 1, 0, cg, hg, we_s, a_s, d_s);
      exp_c = (i % 9 == 0);
      tests_run++;
      if (cg !== exp_c || hg !== !exp_c) begin
        tests_failed++; $display("FAIL host_burst[%0d]: got cpu=%0b host=%0b, required cpu=%0b host=%0b", i, cg, hg, exp_c, !exp_c);
      end
      if (cg) ca++;
      if (hg) hn++;
    end
    idle();
    cycle(1, 0, 5'd16, '0, 0, 0, '0, '0, 0, 0, cg, hg, we_s, a_s, d_s);
    cycle(1, 0, 5'd23, '0, 0, 0, '0, '0, 0, 0, cg, hg, we_s, a_s, d_s);
    idle();
  endtask

  task automatic test_halted();
    logic cg, hg, we_s;
    logic [ADDR_W-1:0] a_s, ha;
    logic [DATA_W-1:0] d_s;
    int host_cnt;
    do_reset();
    ha = 5'd0; host_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      cycle(1, 0, 5'd1, '0, 1, 0, ha, '0, 1, 1, cg, hg, we_s, a_s, d_s);
      if (hg) begin host_cnt++; ha++; end
      tests_run++;
      if (cg !== 1'b0) begin
        tests_failed++; $display("FAIL halted_cpu_gnt[%0d]: got %0b, required 0", i, cg);
      end
    end
    tests_run++;
    if (host_cnt != 20) begin
      tests_failed++; $display("FAIL halted_host_count: got %0d, required 20", host_cnt);
    end
    cycle(0, 0, '0, '0, 1, 0, ha, '0, 0, 1, cg, hg, we_s, a_s, d_s);
    idle();
  endtask

  task automatic test_write_read();
    logic cg, hg, we_s;
    logic [ADDR_W-1:0] a_s;
    logic [DATA_W-1:0] d_s;
    do_reset();
    cycle(0, 0, '0, '0, 1, 1, 5'd31, 16'hBEEF, 0, 0, cg, hg, we_s, a_s, d_s);
    tests_run++;
    if (hg !== 1'b1 || we_s !== 1'b1 || a_s !== 5'd31 || d_s !== 16'hBEEF) begin
      tests_failed++; $display("FAIL host_write: got gnt=%0b we=%0b addr=%0d wdata=%h, required 1 1 31 beef", hg, we_s, a_s, d_s);
    end
    cycle(1, 0, 5'd31, '0, 0, 0, '0, '0, 0, 0, cg, hg, we_s, a_s, d_s);
    tests_run++;
    if (cg !== 1'b1 || we_s !== 1'b0 || a_s !== 5'd31) begin
      tests_failed++; $display("FAIL cpu_read31: got gnt=%0b we=%0b addr=%0d, required 1 0 31", cg, we_s, a_s);
    end
    tests_run++;
    if (cpu_rvalid !== 1'b1 || cpu_rdata !== 16'hBEEF || ram_we !== 1'b0) begin
      tests_failed++; $display("FAIL readback31: got rvalid=%0b rdata=%h ram_we=%0b, required 1 beef 0", cpu_rvalid, cpu_rdata, ram_we);
    end
    idle();
  endtask

  task automatic test_reset_mid_burst();
    logic cg, hg, we_s;
    logic [ADDR_W-1:0] a_s;
    logic [DATA_W-1:0] d_s;
    do_reset();
    for (int i = 0; i < 5; i++)
      cycle(1, 0, 5'd2, '0, 1, 0, 5'(i), '0, 1, 0, cg, hg, we_s, a_s, d_s);
    tests_run++;
    if (hg !== 1'b1 || host_rvalid !== 1'b1) begin
      tests_failed++; $display("FAIL mid_burst_pending: got host_gnt=%0b host_rvalid=%0b, required 1 1", hg, host_rvalid);
    end
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    tests_run++;
    if ({cpu_gnt, host_gnt, cpu_rvalid, host_rvalid, ram_we, ram_addr, ram_wdata, cpu_rdata, host_rdata} !== '0) begin
      tests_failed++;
      $display("FAIL reset_mid_burst_outputs: gnt=%b%b rvalid=%b%b we=%b addr=%h wdata=%h rdata=%h/%h, required all 0",
               cpu_gnt, host_gnt, cpu_rvalid, host_rvalid, ram_we, ram_addr, ram_wdata, cpu_rdata, host_rdata);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    cycle(1, 1, 5'd2, 16'h2222, 1, 1, 5'd3, 16'h3333, 0, 0, cg, hg, we_s, a_s, d_s);
    tests_run++;
    if ({cg, hg} !== 2'b10) begin
      tests_failed++; $display("FAIL post_reset_tie: got cpu=%0b host=%0b, required cpu=1 host=0", cg, hg);
    end
    tests_run++;
    if ({cpu_rvalid, host_rvalid} !== 2'b00) begin
      tests_failed++; $display("FAIL post_reset_rvalid: got %b, required 00", {cpu_rvalid, host_rvalid});
    end
    idle();
  endtask

  initial begin
    for (int i = 0; i < 32; i++) exp_mem[i] = init_val(5'(i));
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    host_req = 0; host_we = 0; host_addr = '0; host_wdata = '0;
    host_lock = 0; cpu_halted = 0;
    test_reset();
    test_cpu_read();
    test_round_robin();
    test_host_burst();
    test_halted();
    test_write_read();
    test_reset_mid_burst();
    idle();
    idle();
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++; $display("FAIL outstanding_reads: got %0d unreturned, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
